// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the timer run-control slice: FSM state
//               encoding and the default debounce timing for a 50 MHz clock.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Run-control FSM states; the state bit doubles as the timer enable.
    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    // 10 ms of stable key level at 50 MHz.
    localparam int c_debounce_bits_50mhz  = 20;
    localparam int c_debounce_count_50mhz = 500000;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronises one raw active-low push button and accepts a
//               level change only after DEBOUNCE_COUNT consecutive cycles of
//               disagreement with the accepted level. Emits a one-cycle press
//               pulse when the accepted level falls; releases are silent.
// Ports       : clk    - system clock
//               rst    - asynchronous active-high reset
//               key_n  - raw button, active-low, asynchronous to clk
//               press  - registered one-cycle pulse per accepted press
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_BITS  = c_debounce_bits_50mhz,
    parameter int DEBOUNCE_COUNT = c_debounce_count_50mhz
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam logic [DEBOUNCE_BITS-1:0] c_cnt_last = DEBOUNCE_BITS'(DEBOUNCE_COUNT - 1);

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_stable;
    logic                     r_stable_d;
    logic [DEBOUNCE_BITS-1:0] r_cnt;
    logic                     r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_cnt      <= '0;
            r_press    <= 1'b0;
        end else begin
            r_sync1    <= key_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // A falling accepted level seen one cycle late keeps the pulse
            // fully registered and exactly one cycle wide.
            r_press    <= r_stable_d & ~r_stable;

            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule : key_debounce
`default_nettype wire

// File: rtl/timer_control.sv
`default_nettype none
// ============================================================================
// Module      : timer_control
// Description : Input conditioning and run control for an up/down timer.
//               Debounces start/stop, direction and load buttons and runs a
//               STOPPED/RUNNING FSM that drives the timer enable, direction
//               and load pulse, auto-stopping a countdown at zero.
// Ports       : clk         - system clock (50 MHz)
//               rst         - asynchronous active-high reset
//               key_start_n - raw start/stop button, active-low
//               key_dir_n   - raw direction button, active-low
//               key_load_n  - raw load button, active-low
//               at_zero     - timer reports all digits zero
//               en          - timer count enable (level)
//               up          - timer direction, 1 = up
//               load        - one-cycle load pulse
//               done        - one-cycle pulse when a countdown hits zero
//               running     - FSM in RUNNING, for an LED
// Revision    : 1.0 - initial release
// ============================================================================
module timer_control
    import timer_pkg::*;
#(
    parameter int   DEBOUNCE_BITS  = c_debounce_bits_50mhz,
    parameter int   DEBOUNCE_COUNT = c_debounce_count_50mhz,
    parameter logic RESET_UP       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_start_n,
    input  logic key_dir_n,
    input  logic key_load_n,
    input  logic at_zero,
    output logic en,
    output logic up,
    output logic load,
    output logic done,
    output logic running
);

    // Key index: 0 = start/stop, 1 = direction, 2 = load.
    logic [2:0] w_keys_n;
    logic [2:0] w_press;
    logic       w_start_press;
    logic       w_dir_press;
    logic       w_load_press;
    logic       w_down_at_zero;

    state_t     r_state;
    logic       r_up;
    logic       r_load;
    logic       r_done;

    assign w_keys_n = {key_load_n, key_dir_n, key_start_n};

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_BITS  (DEBOUNCE_BITS),
            .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
        ) u_key_debounce (
            .clk   (clk),
            .rst   (rst),
            .key_n (w_keys_n[gi]),
            .press (w_press[gi])
        );
    end

    assign w_start_press  = w_press[0];
    assign w_dir_press    = w_press[1];
    assign w_load_press   = w_press[2];

    // Uses the registered direction, so a same-cycle direction toggle only
    // affects the zero check from the following cycle on.
    assign w_down_at_zero = ~r_up & at_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOPPED;
            r_up    <= RESET_UP;
            r_load  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;

            // Direction toggles independently of any start/load action.
            if (w_dir_press) begin
                r_up <= ~r_up;
            end

            if (w_load_press) begin
                // Load overrides everything, including a same-cycle start
                // and a countdown reaching zero.
                r_load  <= 1'b1;
                r_state <= ST_STOPPED;
            end else begin
                case (r_state)
                    ST_STOPPED: begin
                        // Refuse to start a countdown already at zero so the
                        // timer never wraps below zero.
                        if (w_start_press && !w_down_at_zero) begin
                            r_state <= ST_RUNNING;
                        end
                    end
                    ST_RUNNING: begin
                        if (w_down_at_zero) begin
                            r_state <= ST_STOPPED;
                            r_done  <= 1'b1;
                        end else if (w_start_press) begin
                            r_state <= ST_STOPPED;
                        end
                    end
                    default: r_state <= ST_STOPPED;
                endcase
            end
        end
    end

    assign en      = (r_state == ST_RUNNING);
    assign running = (r_state == ST_RUNNING);
    assign up      = r_up;
    assign load    = r_load;
    assign done    = r_done;

endmodule : timer_control
`default_nettype wire

// File: tb/tb_timer_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_control
// Description : Self-checking bench for timer_control with a short debounce
//               window. A cycle-level reference model built from the button
//               and run-control rules is compared every cycle; directed
//               sequences and a table of key actions check the key corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_control;

    localparam int DB    = 4;
    localparam int DBITS = 3;

    logic clk         = 1'b0;
    logic rst         = 1'b1;
    logic key_start_n = 1'b1;
    logic key_dir_n   = 1'b1;
    logic key_load_n  = 1'b1;
    logic at_zero     = 1'b0;
    logic en, up, load, done, running;

    always #5 clk = ~clk;

    timer_control #(
        .DEBOUNCE_BITS  (DBITS),
        .DEBOUNCE_COUNT (DB),
        .RESET_UP       (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_start_n (key_start_n),
        .key_dir_n   (key_dir_n),
        .key_load_n  (key_load_n),
        .at_zero     (at_zero),
        .en          (en),
        .up          (up),
        .load        (load),
        .done        (done),
        .running     (running)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Per key: last two raw samples (synchroniser delay), history of the
    // synchronised level, accepted level, and pending/visible press.
    logic [1:0] m_raw    [3];
    logic [7:0] m_shist  [3];
    logic       m_stable [3];
    logic       m_fell   [3];
    logic       m_press  [3];
    logic       m_running, m_up, m_load, m_done;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_raw[i]    = 2'b11;
            m_shist[i]  = 8'hFF;
            m_stable[i] = 1'b1;
            m_fell[i]   = 1'b0;
            m_press[i]  = 1'b0;
        end
        m_running = 1'b0;
        m_up      = 1'b1;
        m_load    = 1'b0;
        m_done    = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [2:0] keys;
        logic       down_zero;
        logic       s;
        keys      = {key_load_n, key_dir_n, key_start_n};
        down_zero = !m_up && at_zero;
        m_load    = 1'b0;
        m_done    = 1'b0;
        if (m_press[2]) begin
            m_load    = 1'b1;
            m_running = 1'b0;
        end else if (m_running && down_zero) begin
            m_running = 1'b0;
            m_done    = 1'b1;
        end else if (m_press[0]) begin
            if (m_running) m_running = 1'b0;
            else if (!down_zero) m_running = 1'b1;
        end
        if (m_press[1]) m_up = !m_up;
        for (int i = 0; i < 3; i++) begin
            m_press[i] = m_fell[i];
            s          = m_raw[i][1];
            m_raw[i]   = {m_raw[i][0], keys[i]};
            m_shist[i] = {m_shist[i][6:0], s};
            m_fell[i]  = 1'b0;
            // Accept the new level once the last DB synchronised samples all
            // disagree with the accepted level.
            if (m_shist[i][DB-1:0] == {DB{!m_stable[i]}}) begin
                m_stable[i] = !m_stable[i];
                m_fell[i]   = !m_stable[i];
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock: model advances at the edge, outputs compared mid-cycle.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        checks++;
        if ({en, up, load, done, running} !== {m_running, m_up, m_load, m_done, m_running}) begin
            failures++;
            $display("FAIL model_cycle t=%0t en,up,load,done,running actual=%b required=%b",
                     $time, {en, up, load, done, running},
                     {m_running, m_up, m_load, m_done, m_running});
        end
    endtask

    // Reset asserted between edges; outputs must clear before any clock.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {en, up, load, done, running}, 5'b01000);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_release(input logic s, input logic d, input logic l,
                                 output int loads, output int dones);
        loads = 0;
        dones = 0;
        key_start_n = !s;
        key_dir_n   = !d;
        key_load_n  = !l;
        for (int k = 0; k < 10; k++) begin
            step();
            loads += int'(load);
            dones += int'(done);
        end
        key_start_n = 1'b1;
        key_dir_n   = 1'b1;
        key_load_n  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            loads += int'(load);
            dones += int'(done);
        end
    endtask

    typedef struct {
        logic k_start, k_dir, k_load, az;
        logic exp_en, exp_up;
        int   exp_loads, exp_dones;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int   loads, dones, rise_at, rises, en_at, up_at;
        logic prev;
        int   cnt [3];
        logic kn  [3];

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1};

        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {en, up, load, done, running}, 5'b01000);

        // Idle keys: nothing may move.
        for (int k = 0; k < 50; k++) begin
            step();
            check("idle_outputs", {en, up, load, done}, 4'b0100);
        end

        // Bounces shorter than the debounce window.
        for (int b = 0; b < 5; b++) begin
            key_start_n = 1'b0;
            repeat (3) step();
            key_start_n = 1'b1;
            repeat (4) step();
        end
        check("bounce_no_start", {en, load, done}, 3'b000);

        // Long hold: en rises exactly 8 cycles after the first low edge, once.
        key_start_n = 1'b0;
        rise_at = -1;
        rises   = 0;
        prev    = en;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (en && !prev) begin
                rises++;
                if (rise_at < 0) rise_at = k;
            end
            prev = en;
        end
        check("start_latency", rise_at, 8);
        check("start_single_transition", rises, 1);
        key_start_n = 1'b1;
        repeat (10) step();
        check("release_no_action", en, 1);
        press_release(1'b1, 1'b0, 1'b0, loads, dones);
        check("second_press_stops", en, 0);

        // Table of key actions from a known state (STOPPED, up=1).
        for (int v = 0; v < 13; v++) begin
            at_zero = vecs[v].az;
            press_release(vecs[v].k_start, vecs[v].k_dir, vecs[v].k_load, loads, dones);
            check($sformatf("vec%0d_en", v), en, vecs[v].exp_en);
            check($sformatf("vec%0d_up", v), up, vecs[v].exp_up);
            check($sformatf("vec%0d_load_pulses", v), loads, vecs[v].exp_loads);
            check($sformatf("vec%0d_done_pulses", v), dones, vecs[v].exp_dones);
        end

        // Dir and start together from STOPPED with up=1: both change at once.
        at_zero = 1'b0;
        press_release(1'b0, 1'b1, 1'b0, loads, dones);
        check("dir_restore_up", up, 1);
        key_start_n = 1'b0;
        key_dir_n   = 1'b0;
        en_at = -1;
        up_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (en && en_at < 0) en_at = k;
            if (!up && up_at < 0) up_at = k;
        end
        check("dir_start_en_cycle", en_at, 8);
        check("dir_start_up_cycle", up_at, 8);
        key_start_n = 1'b1;
        key_dir_n   = 1'b1;
        repeat (10) step();
        check("dir_start_no_done", {en, done}, 2'b10);

        // Asynchronous reset while running.
        async_reset();
        repeat (5) step();

        // Randomised key activity and at_zero against the model.
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            kn[i]  = 1'b1;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (cnt[i] == 0) begin
                    kn[i]  = !kn[i];
                    cnt[i] = int'($urandom_range(1, 9));
                end else begin
                    cnt[i]--;
                end
            end
            key_start_n = kn[0];
            key_dir_n   = kn[1];
            key_load_n  = kn[2];
            if ($urandom_range(0, 15) == 0) at_zero = !at_zero;
            if (c == 1500) async_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_timer_control
`default_nettype wire

// File: doc/timer_control.md
Name: timer_control

Overview:
- Input-conditioning and run-control stage that sits directly upstream of upDownTimer.
- Turns three raw active-low push buttons (start/stop, direction, load) into clean synchronous control.
- Drives the timer's en, up and load inputs.
- Consumes the timer's at-zero flag to auto-stop a countdown and pulse done.

Parameters:
- DEBOUNCE_BITS, 20, width of each debounce counter.
- DEBOUNCE_COUNT, 500000, consecutive stable clk cycles needed to accept a key change (10 ms at 50 MHz).
- RESET_UP, 1, value of up after reset (1 = count up).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; one clock domain, reset is asynchronous and active-high.
- key_start_n  in  1  raw start/stop button, active-low, asynchronous to clk.
- key_dir_n  in  1  raw direction button, active-low, asynchronous.
- key_load_n  in  1  raw load button, active-low, asynchronous.
- at_zero  in  1  from timer: all digits are 0, synchronous to clk.
- en  out  1  timer count enable (level).
- up  out  1  timer direction: 1 = up, 0 = down (level).
- load  out  1  one-cycle load pulse to timer.
- done  out  1  one-cycle pulse when a countdown reaches zero.
- running  out  1  FSM state indicator (1 = RUNNING), for LED.

Behaviour:
- Reset (async, rst=1): en=0, up=RESET_UP, load=0, done=0, running=0, FSM=STOPPED.
  - All synchronizer flops reset to 1 (released).
  - Debounce stable values reset to 1; counters reset to 0.
  - Reset mid-debounce discards a partial count.
- Per key, a debouncer does the following:
  - A 2-flop synchronizer produces s.
  - The counter increments each cycle s != stable and clears to 0 each cycle s == stable.
  - When the counter reaches DEBOUNCE_COUNT-1 while s != stable, stable takes s and the counter clears.
  - A press pulse (registered) is high for exactly one cycle after stable goes 1->0. Release produces no pulse.
- Latency: a key held low continuously from the first sampling edge gives a press pulse exactly DEBOUNCE_COUNT+3 cycles later.
  - A glitch shorter than DEBOUNCE_COUNT cycles produces no pulse.
  - Holding a key gives one pulse only; no auto-repeat.
- FSM states are STOPPED (en=0) and RUNNING (en=1). Transitions are evaluated on press pulses in the cycle they are high:
  - load press, any state: load=1 next cycle for 1 cycle; go STOPPED. Highest priority; a same-cycle start press is ignored.
  - start press in STOPPED: go RUNNING, unless up=0 and at_zero=1, in which case stay STOPPED (no underflow wrap).
  - start press in RUNNING: go STOPPED.
  - RUNNING with up=0 and at_zero=1: go STOPPED; done=1 for 1 cycle. This takes precedence over a same-cycle start press; the result is STOPPED with done=1.
  - dir press, any state: toggle up the next cycle, and is applied together with any start/load press in the same cycle.
  - The auto-stop check uses the new up value only from the cycle after the toggle.
- All outputs are registered; en/up/load/done change one cycle after the causing pulse or at_zero edge.
- done never asserts while counting up; at_zero is ignored when up=1.

Decomposition:
- Shared package/include timer_pkg:
  - FSM state encodings ST_STOPPED=1'b0, ST_RUNNING=1'b1.
  - Default DEBOUNCE constant for 50 MHz.
- Sub-module key_debounce (params DEBOUNCE_BITS, DEBOUNCE_COUNT):
  - Ports clk, rst, key_n, press.
  - Instantiated three times.
- The FSM and output registers live in timer_control.

Test Plan (bench overrides DEBOUNCE_COUNT=4, DEBOUNCE_BITS=3):
- Reset then idle keys high for 50 cycles -> en=0, up=1, load=0, done=0 throughout; assert rst mid-run -> en=0 immediately (async).
- key_start_n low 3 cycles then high (bounce), repeated 5 times -> no press, en stays 0. Then hold low 20 cycles -> en=1 exactly 4+3+1=8 cycles after first low edge, one transition only; second hold -> en=0.
- While RUNNING, dir press -> up toggles 1->0 one cycle after pulse, en unchanged. Then drive at_zero=1 -> next cycle en=0, done=1 for exactly 1 cycle, running=0.
- With up=0 and at_zero=1 held, start press -> en stays 0, done stays 0. Then dir press (up=1) and start press -> en=1, at_zero ignored.
- RUNNING, start and load keys pressed identically (same-cycle pulses) -> load=1 for 1 cycle, en=0, no re-start.
- Dir and start pressed identically from STOPPED, up=1 -> next cycle up=0 and en=1 together; at_zero=0 so no done.
